// File: rtl/cache_sel2_sched.sv
// Round-robin scheduler that feeds one latched cache request to pipe 0, pipe 1 or both.
// A request waits DELAY settle cycles after its grant, then holds each routed output until that pipe accepts it.
module cache_sel2_sched #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int DELAY = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_mask,
  input  logic [DW*NREQ-1:0] req_data,
  output logic              out_valid0,
  input  logic              out_ready0,
  output logic              out_valid1,
  input  logic              out_ready1,
  output logic [DW-1:0]     out_data,
  output logic              o_fire,
  output logic [IW-1:0]     o_grant_id,
  output logic              o_drop
);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

  state_t        state_q;
  logic [IW-1:0] rrPtr_q;
  logic [IW-1:0] grantId_q;
  logic [1:0]    mask_q;
  logic [1:0]    done_q;
  logic [1:0]    done_d;
  logic [3:0]    cnt_q;
  logic [DW-1:0] data_q;
  logic          fire_q;

  logic grantFound;
  int   grantSel;
  int   candIdx;

  // The search starts at rrPtr_q, so the requester granted last has the lowest priority next time.
  always_comb begin
    grantFound = 1'b0;
    grantSel   = 0;
    candIdx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      candIdx = (int'(rrPtr_q) + i) % NREQ;
      if (!grantFound && req_valid[candIdx]) begin
        grantFound = 1'b1;
        grantSel   = candIdx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grantFound) begin
      req_ready[grantSel] = 1'b1;
    end
  end

  assign out_valid0 = (state_q == DRIVE) & mask_q[0] & ~done_q[0];
  assign out_valid1 = (state_q == DRIVE) & mask_q[1] & ~done_q[1];
  assign o_drop     = (state_q == DRIVE) & (mask_q == 2'b00);
  assign out_data   = data_q;
  assign o_fire     = fire_q;
  assign o_grant_id = grantId_q;

  always_comb begin
    done_d = done_q | ({out_valid1, out_valid0} & {out_ready1, out_ready0});
  end

  // WAIT covers DELAY cycles, so the first DRIVE cycle lands DELAY+1 cycles after the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      grantId_q <= '0;
      mask_q    <= 2'b00;
      done_q    <= 2'b00;
      cnt_q     <= 4'd0;
      data_q    <= '0;
      fire_q    <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            data_q    <= req_data[grantSel*DW +: DW];
            mask_q    <= req_mask[2*grantSel +: 2];
            grantId_q <= IW'(grantSel);
            rrPtr_q   <= (grantSel == NREQ - 1) ? '0 : IW'(grantSel + 1);
            done_q    <= 2'b00;
            fire_q    <= 1'b1;
            cnt_q     <= 4'(DELAY);
            state_q   <= (DELAY == 0) ? DRIVE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          done_q <= done_d;
          if ((mask_q & ~done_d) == 2'b00) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sel2_sched.sv
// Scoreboard bench for cache_sel2_sched: directed requests push expected grants/payloads,
// and a negedge monitor pops and compares them whenever the DUT fires, hands off or drops.
module tb_cache_sel2_sched;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int DELAY = 4;
  localparam int IW    = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_mask;
  logic [DW*NREQ-1:0] req_data;
  logic              out_valid0;
  logic              out_ready0;
  logic              out_valid1;
  logic              out_ready1;
  logic [DW-1:0]     out_data;
  logic              o_fire;
  logic [IW-1:0]     o_grant_id;
  logic              o_drop;

  typedef struct {
    int          id;
    logic [31:0] data;
  } fire_t;

  fire_t       fireQ[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          dropQ[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic prevV0 = 1'b0, prevR0 = 1'b0, prevV1 = 1'b0, prevR1 = 1'b0, prevRst = 1'b1;

  cache_sel2_sched #(.NREQ(NREQ), .DW(DW), .DELAY(DELAY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .req_data(req_data),
    .out_valid0(out_valid0), .out_ready0(out_ready0),
    .out_valid1(out_valid1), .out_ready1(out_ready1),
    .out_data(out_data), .o_fire(o_fire),
    .o_grant_id(o_grant_id), .o_drop(o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagUnexpected(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] mask, input logic [31:0] data);
    req_mask[2*idx +: 2] = mask;
    req_data[DW*idx +: DW] = data;
  endtask

  task automatic expectGrant(input int idx, input logic [1:0] mask, input logic [31:0] data);
    fire_t f;
    f.id = idx;
    f.data = data;
    fireQ.push_back(f);
    if (mask[0]) q0.push_back(data);
    if (mask[1]) q1.push_back(data);
    if (mask == 2'b00) dropQ.push_back(idx);
  endtask

  // Monitor: every fire, handshake and drop must match the head of its queue.
  always @(negedge clk) begin
    fire_t       f;
    logic [31:0] d;
    int          id;
    if (!rst) begin
      if (o_fire) begin
        if (fireQ.size() == 0) flagUnexpected("unexpected_fire");
        else begin
          f = fireQ.pop_front();
          checkOutput("fire_grant_id", 64'(o_grant_id), 64'(f.id));
          checkOutput("fire_data", 64'(out_data), 64'(f.data));
        end
      end
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) flagUnexpected("unexpected_hs0");
        else begin
          d = q0.pop_front();
          checkOutput("hs0_data", 64'(out_data), 64'(d));
        end
      end
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) flagUnexpected("unexpected_hs1");
        else begin
          d = q1.pop_front();
          checkOutput("hs1_data", 64'(out_data), 64'(d));
        end
      end
      if (o_drop) begin
        if (dropQ.size() == 0) flagUnexpected("unexpected_drop");
        else begin
          id = dropQ.pop_front();
          checkOutput("drop_grant_id", 64'(o_grant_id), 64'(id));
        end
      end
      if (prevV0 && !prevR0 && !prevRst) checkOutput("hold_valid0", 64'(out_valid0), 64'd1);
      if (prevV1 && !prevR1 && !prevRst) checkOutput("hold_valid1", 64'(out_valid1), 64'd1);
    end
    prevV0  = out_valid0;
    prevR0  = out_ready0;
    prevV1  = out_valid1;
    prevR1  = out_ready1;
    prevRst = rst;
  end

  initial begin
    wait (cyc >= 3000);
    flagUnexpected("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int grants;
    int budget;
    int expId[5];
    expId = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req_valid = 4'hF;
    req_mask = '0;
    req_data = '0;
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;

    // Reset with every requester asserting.
    nextCycle();
    @(negedge clk) checkOutput("rst_req_ready_c1", 64'(req_ready), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_req_ready_c2", 64'(req_ready), 64'd0);
    checkOutput("rst_outputs", 64'({out_valid0, out_valid1, out_data, o_fire, o_grant_id, o_drop}), 64'd0);
    nextCycle();
    rst = 1'b0;
    req_valid = 4'h0;
    @(negedge clk) checkOutput("idle_no_grant", 64'(req_ready), 64'd0);

    // Single request on pipe 0.
    nextCycle();
    applyStimulus(0, 2'b01, 32'h0000_00A5);
    req_valid = 4'b0001;
    out_ready0 = 1'b1;
    expectGrant(0, 2'b01, 32'h0000_00A5);
    @(negedge clk) checkOutput("single_req_ready", 64'(req_ready), 64'b0001);
    nextCycle();
    req_valid = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk) checkOutput("single_wait_valid0", 64'(out_valid0), 64'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("single_drive_valid0", 64'(out_valid0), 64'd1);
    checkOutput("single_drive_valid1", 64'(out_valid1), 64'd0);
    nextCycle();
    @(negedge clk) checkOutput("single_after_valid0", 64'(out_valid0), 64'd0);

    // Broadcast from requester 1; pipe 1 stalls for three cycles.
    nextCycle();
    applyStimulus(1, 2'b11, 32'h1111_0001);
    req_valid = 4'b0010;
    expectGrant(1, 2'b11, 32'h1111_0001);
    @(negedge clk) checkOutput("bcast_req_ready", 64'(req_ready), 64'b0010);
    nextCycle();
    req_valid = 4'b0000;
    repeat (3) nextCycle();
    nextCycle();
    @(negedge clk) checkOutput("bcast_valids_t5", 64'({out_valid0, out_valid1}), 64'b11);
    nextCycle();
    @(negedge clk) checkOutput("bcast_valids_t6", 64'({out_valid0, out_valid1}), 64'b01);
    nextCycle();
    @(negedge clk) checkOutput("bcast_valids_t7", 64'({out_valid0, out_valid1}), 64'b01);
    nextCycle();
    out_ready1 = 1'b1;
    @(negedge clk) checkOutput("bcast_valids_t8", 64'({out_valid0, out_valid1}), 64'b01);
    nextCycle();
    out_ready1 = 1'b0;
    @(negedge clk) checkOutput("bcast_valids_t9", 64'({out_valid0, out_valid1}), 64'b00);

    // Mask 00 on requester 2 is dropped.
    nextCycle();
    applyStimulus(2, 2'b00, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    expectGrant(2, 2'b00, 32'hDEAD_BEEF);
    @(negedge clk) checkOutput("drop_req_ready", 64'(req_ready), 64'b0100);
    nextCycle();
    req_valid = 4'b0000;
    repeat (3) nextCycle();
    @(negedge clk) checkOutput("drop_before", 64'(o_drop), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("drop_pulse", 64'(o_drop), 64'd1);
    checkOutput("drop_no_valid", 64'({out_valid0, out_valid1}), 64'b00);
    nextCycle();
    @(negedge clk) checkOutput("drop_after", 64'(o_drop), 64'd0);

    // All requesting: pointer sits at 3, so requester 3 wins; reset it mid-DRIVE.
    nextCycle();
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
    applyStimulus(3, 2'b10, 32'h3333_3333);
    req_valid = 4'hF;
    expectGrant(3, 2'b10, 32'h3333_3333);
    @(negedge clk) checkOutput("rr_ptr3_req_ready", 64'(req_ready), 64'b1000);
    nextCycle();
    req_valid = 4'h0;
    repeat (4) nextCycle();
    rst = 1'b1;
    @(negedge clk) checkOutput("rstdrive_valid1_pre", 64'({out_valid0, out_valid1}), 64'b01);
    nextCycle();
    rst = 1'b0;
    q1.delete();
    @(negedge clk);
    checkOutput("rstdrive_valid1_post", 64'(out_valid1), 64'd0);
    checkOutput("rstdrive_grant_id", 64'(o_grant_id), 64'd0);

    // Round-robin sweep after reset: 0,1,2,3,0.
    nextCycle();
    applyStimulus(0, 2'b01, 32'hC0C0_0000);
    applyStimulus(1, 2'b10, 32'hC1C1_0001);
    applyStimulus(2, 2'b11, 32'hC2C2_0002);
    applyStimulus(3, 2'b01, 32'hC3C3_0003);
    expectGrant(0, 2'b01, 32'hC0C0_0000);
    expectGrant(1, 2'b10, 32'hC1C1_0001);
    expectGrant(2, 2'b11, 32'hC2C2_0002);
    expectGrant(3, 2'b01, 32'hC3C3_0003);
    expectGrant(0, 2'b01, 32'hC0C0_0000);
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    req_valid = 4'hF;
    grants = 0;
    budget = 0;
    while (grants < 5 && budget < 200) begin
      @(negedge clk);
      if (req_ready != 4'h0) begin
        checkOutput("rr_req_ready", 64'(req_ready), 64'(4'(1) << expId[grants]));
        grants++;
      end
      budget++;
      nextCycle();
    end
    req_valid = 4'h0;
    checkOutput("rr_grant_count", 64'(grants), 64'd5);

    budget = 0;
    while ((fireQ.size() + q0.size() + q1.size() + dropQ.size()) != 0 && budget < 100) begin
      nextCycle();
      budget++;
    end
    repeat (2) nextCycle();
    checkOutput("drain_fireQ", 64'(fireQ.size()), 64'd0);
    checkOutput("drain_q0", 64'(q0.size()), 64'd0);
    checkOutput("drain_q1", 64'(q1.size()), 64'd0);
    checkOutput("drain_dropQ", 64'(dropQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
